// File: rtl/msftdvip_apb_splitter_pkg.sv
// Shared types and default address map for the APB 1-to-N splitter.
// The decoder, bus interface and splitter top all import this package.
package msftdvip_apb_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int DEF_NUM_SLV    = 4;
    localparam int DEF_TMO_CYCLES = 256;

    localparam logic [31:0] DEF_SLV_BASE [DEF_NUM_SLV] = '{
        32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000
    };
    localparam logic [31:0] DEF_SLV_MASK [DEF_NUM_SLV] = '{default: 32'hFFFF_F000};

    // Width needed to index n items; never returns zero so vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msftdvip_apb_splitter_if.sv
// Upstream APB port, downstream shared bus and status signals of the splitter.
// slave = splitter side, master = the agent driving requests and modelling completers.
interface msftdvip_apb_splitter_if
    import msftdvip_apb_splitter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = DEF_NUM_SLV
);
    localparam int STRB_W = DATA_W / 8;
    localparam int ERR_W  = idx_width(NUM_SLV) + 1;

    logic                       psel_i;
    logic                       penable_i;
    logic                       pwrite_i;
    logic [ADDR_W-1:0]          paddr_i;
    logic [2:0]                 pprot_i;
    logic [STRB_W-1:0]          pstrb_i;
    logic [DATA_W-1:0]          pwdata_i;
    logic [DATA_W-1:0]          prdata_o;
    logic                       pready_o;
    logic                       psuberr_o;

    logic [NUM_SLV-1:0]         psel_o;
    logic                       penable_o;
    logic                       pwrite_o;
    logic [ADDR_W-1:0]          paddr_o;
    logic [2:0]                 pprot_o;
    logic [STRB_W-1:0]          pstrb_o;
    logic [DATA_W-1:0]          pwdata_o;
    logic [NUM_SLV*DATA_W-1:0]  prdata_i;
    logic [NUM_SLV-1:0]         pready_i;
    logic [NUM_SLV-1:0]         pslverr_i;

    logic                       tmo_o;
    logic [ERR_W-1:0]           err_slot_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pprot_i, pstrb_i, pwdata_i,
        output prdata_o, pready_o, psuberr_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pprot_o, pstrb_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i,
        output tmo_o, err_slot_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pprot_i, pstrb_i, pwdata_i,
        input  prdata_o, pready_o, psuberr_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pprot_o, pstrb_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i,
        input  tmo_o, err_slot_o
    );

endinterface

// File: rtl/msftdvip_apb_addr_dec.sv
// Combinational address decoder: reports whether any slot matches and the lowest
// matching slot index, so overlapping windows resolve deterministically.
module msftdvip_apb_addr_dec
    import msftdvip_apb_splitter_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                NUM_SLV = DEF_NUM_SLV,
    parameter int                IDX_W   = idx_width(NUM_SLV),
    parameter logic [ADDR_W-1:0] SLV_BASE [NUM_SLV] = DEF_SLV_BASE,
    parameter logic [ADDR_W-1:0] SLV_MASK [NUM_SLV] = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [NUM_SLV-1:0] match;

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_match
        assign match[gi] = ((addr_i & SLV_MASK[gi]) == SLV_BASE[gi]);
    end

    // Scan downward so the last assignment is the lowest matching index.
    always_comb begin
        hit_o = |match;
        idx_o = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/msftdvip_apb_splitter.sv
// APB 1-to-N splitter: decodes the upstream request, replays it on a registered shared
// downstream bus with one-hot select, and returns the response with timeout/error tracking.
module msftdvip_apb_splitter
    import msftdvip_apb_splitter_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLV    = DEF_NUM_SLV,
    parameter logic [ADDR_W-1:0] SLV_BASE [NUM_SLV] = DEF_SLV_BASE,
    parameter logic [ADDR_W-1:0] SLV_MASK [NUM_SLV] = DEF_SLV_MASK,
    parameter int                TMO_CYCLES = DEF_TMO_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    msftdvip_apb_splitter_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(NUM_SLV);
    localparam int ERR_W  = IDX_W + 1;
    localparam int CNT_W  = idx_width(TMO_CYCLES);

    apb_state_e         state_q, state_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [2:0]         pprot_q, pprot_d;
    logic [STRB_W-1:0]  pstrb_q, pstrb_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [IDX_W-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pready_q, pready_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;
    logic               psuberr_q, psuberr_d;
    logic               tmo_q, tmo_d;
    logic [ERR_W-1:0]   err_slot_q, err_slot_d;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               sel_rdy;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

    msftdvip_apb_addr_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_SLV  (NUM_SLV),
        .IDX_W    (IDX_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_dec (
        .addr_i (bus.paddr_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    assign sel_rdy   = bus.pready_i[slot_q];
    assign sel_err   = bus.pslverr_i[slot_q];
    assign sel_rdata = bus.prdata_i[slot_q*DATA_W +: DATA_W];

    always_comb begin
        state_d    = state_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pprot_d    = pprot_q;
        pstrb_d    = pstrb_q;
        pwdata_d   = pwdata_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        err_slot_d = err_slot_q;
        // Response-side signals are single-cycle: only the transition into RESP raises them.
        pready_d   = 1'b0;
        prdata_d   = '0;
        psuberr_d  = 1'b0;
        tmo_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.psel_i && !bus.penable_i) begin
                    pwrite_d = bus.pwrite_i;
                    paddr_d  = bus.paddr_i;
                    pprot_d  = bus.pprot_i;
                    pstrb_d  = bus.pstrb_i;
                    pwdata_d = bus.pwdata_i;
                    slot_d   = dec_idx;
                    if (dec_hit) begin
                        psel_d          = '0;
                        psel_d[dec_idx] = 1'b1;
                        state_d         = SETUP;
                    end else begin
                        pready_d   = 1'b1;
                        psuberr_d  = 1'b1;
                        err_slot_d = {1'b1, {IDX_W{1'b0}}};
                        state_d    = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Ready wins over the terminal count so a late completer still succeeds.
                if (sel_rdy) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = pwrite_q ? '0 : sel_rdata;
                    psuberr_d = sel_err;
                    if (sel_err) begin
                        err_slot_d = {1'b0, slot_q};
                    end
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TMO_CYCLES - 1)) begin
                    psel_d     = '0;
                    penable_d  = 1'b0;
                    pready_d   = 1'b1;
                    psuberr_d  = 1'b1;
                    tmo_d      = 1'b1;
                    err_slot_d = {1'b0, slot_q};
                    state_d    = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pprot_q    <= '0;
            pstrb_q    <= '0;
            pwdata_q   <= '0;
            slot_q     <= '0;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            psuberr_q  <= 1'b0;
            tmo_q      <= 1'b0;
            err_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pprot_q    <= pprot_d;
            pstrb_q    <= pstrb_d;
            pwdata_q   <= pwdata_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            psuberr_q  <= psuberr_d;
            tmo_q      <= tmo_d;
            err_slot_q <= err_slot_d;
        end
    end

    assign bus.psel_o     = psel_q;
    assign bus.penable_o  = penable_q;
    assign bus.pwrite_o   = pwrite_q;
    assign bus.paddr_o    = paddr_q;
    assign bus.pprot_o    = pprot_q;
    assign bus.pstrb_o    = pstrb_q;
    assign bus.pwdata_o   = pwdata_q;
    assign bus.pready_o   = pready_q;
    assign bus.prdata_o   = prdata_q;
    assign bus.psuberr_o  = psuberr_q;
    assign bus.tmo_o      = tmo_q;
    assign bus.err_slot_o = err_slot_q;

endmodule

// File: tb/tb_msftdvip_apb_splitter.sv
// Directed bench for the APB splitter: cycle-accurate checks of select, enable, response
// latency, timeout, error slot tracking and reset behaviour against configurable completers.
module tb_msftdvip_apb_splitter;
    import msftdvip_apb_splitter_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 4;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msftdvip_apb_splitter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

    msftdvip_apb_splitter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLV    (NUM_SLV),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Completer model: slot k answers after wait_cfg[k] access-phase wait states.
    int                wait_cfg [NUM_SLV];
    logic [DATA_W-1:0] rd_data  [NUM_SLV];
    logic [NUM_SLV-1:0] err_cfg;
    int                acc_cyc;

    always @(posedge clk) begin
        acc_cyc <= (|bus.psel_o && bus.penable_o) ? acc_cyc + 1 : 0;
    end

    always_comb begin
        bus.pready_i  = '0;
        bus.pslverr_i = '0;
        bus.prdata_i  = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            bus.prdata_i[k*DATA_W +: DATA_W] = rd_data[k];
            if (bus.psel_o[k] && bus.penable_o && (acc_cyc >= wait_cfg[k])) begin
                bus.pready_i[k]  = 1'b1;
                bus.pslverr_i[k] = err_cfg[k];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One upstream transfer; lat is the cycle index (T0 = setup) at which pready_o is due.
    task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int lat,
                           input logic [3:0] exp_sel, input logic [31:0] exp_rd,
                           input logic exp_err, input logic exp_tmo, input logic drop_psel);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.paddr_i   = addr;
        bus.pwrite_i  = wr;
        bus.pwdata_i  = wdata;
        bus.pstrb_i   = strb;
        bus.pprot_i   = 3'b010;
        for (int t = 1; t <= lat; t++) begin
            tick();
            if (t == 1) bus.penable_i = 1'b1;
            if (drop_psel && t == 2) begin
                bus.psel_i    = 1'b0;
                bus.penable_i = 1'b0;
            end
            if (t < lat) begin
                chk({tag, ":pready_low"}, bus.pready_o, 1'b0);
                chk({tag, ":prdata_idle"}, bus.prdata_o, 32'h0);
                chk({tag, ":tmo_low"}, bus.tmo_o, 1'b0);
                chk({tag, ":psel"}, bus.psel_o, exp_sel);
                chk({tag, ":penable"}, bus.penable_o, (t >= 2));
                chk({tag, ":pwdata"}, bus.pwdata_o, wdata);
                chk({tag, ":pstrb"}, bus.pstrb_o, strb);
                if (t == 1) begin
                    chk({tag, ":paddr"}, bus.paddr_o, addr);
                    chk({tag, ":pwrite"}, bus.pwrite_o, wr);
                    chk({tag, ":pprot"}, bus.pprot_o, 3'b010);
                end
            end else begin
                chk({tag, ":pready"}, bus.pready_o, 1'b1);
                chk({tag, ":prdata"}, bus.prdata_o, exp_rd);
                chk({tag, ":psuberr"}, bus.psuberr_o, exp_err);
                chk({tag, ":tmo"}, bus.tmo_o, exp_tmo);
                chk({tag, ":psel_resp"}, bus.psel_o, 4'b0000);
                chk({tag, ":penable_resp"}, bus.penable_o, 1'b0);
            end
        end
        tick();
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        chk({tag, ":pready_after"}, bus.pready_o, 1'b0);
        chk({tag, ":prdata_after"}, bus.prdata_o, 32'h0);
        chk({tag, ":tmo_after"}, bus.tmo_o, 1'b0);
        chk({tag, ":psuberr_after"}, bus.psuberr_o, 1'b0);
        $display("xfer %s addr=%08h wr=%0d lat=%0d done", tag, addr, wr, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = '0;
        bus.pprot_i   = '0;
        bus.pstrb_i   = '0;
        bus.pwdata_i  = '0;
        err_cfg       = '0;
        for (int k = 0; k < NUM_SLV; k++) wait_cfg[k] = 0;
        rd_data[0] = 32'h0BAD_F00D;
        rd_data[1] = 32'hDEAD_BEEF;
        rd_data[2] = 32'hC0FF_EE02;
        rd_data[3] = 32'h3333_3333;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst:pready", bus.pready_o, 1'b0);
        chk("rst:psel", bus.psel_o, 4'b0000);
        chk("rst:penable", bus.penable_o, 1'b0);
        chk("rst:tmo", bus.tmo_o, 1'b0);
        chk("rst:err_slot", bus.err_slot_o, 3'b000);
        chk("rst:prdata", bus.prdata_o, 32'h0);
        chk("rst:paddr", bus.paddr_o, 32'h0);
        $display("reset check done");
        rst = 1'b0;
        tick();

        do_xfer("rd_s1", 32'h0000_1004, 1'b0, 32'h0, 4'hF, 3, 4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

        wait_cfg[3] = 3;
        do_xfer("wr_s3", 32'h0000_3000, 1'b1, 32'h1234_5678, 4'hF, 6, 4'b1000, 32'h0, 1'b0, 1'b0, 1'b0);

        do_xfer("unmap", 32'h0001_0000, 1'b0, 32'h0, 4'hF, 1, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("unmap:err_slot", bus.err_slot_o, 3'b100);

        wait_cfg[2] = 1000;
        do_xfer("tmo_s2", 32'h0000_2000, 1'b0, 32'h0, 4'hF, 18, 4'b0100, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("tmo_s2:err_slot", bus.err_slot_o, 3'b010);

        do_xfer("rd_s0", 32'h0000_0010, 1'b0, 32'h0, 4'hF, 3, 4'b0001, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        chk("rd_s0:err_sticky", bus.err_slot_o, 3'b010);

        wait_cfg[2] = TMO - 1;
        do_xfer("tc_s2", 32'h0000_2008, 1'b0, 32'h0, 4'hF, 18, 4'b0100, 32'hC0FF_EE02, 1'b0, 1'b0, 1'b0);

        err_cfg[1]  = 1'b1;
        wait_cfg[1] = 1;
        do_xfer("slverr_s1", 32'h0000_1FFC, 1'b0, 32'h0, 4'hF, 4, 4'b0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        chk("slverr_s1:err_slot", bus.err_slot_o, 3'b001);
        err_cfg[1] = 1'b0;

        wait_cfg[0] = 2;
        do_xfer("drop_s0", 32'h0000_0004, 1'b1, 32'hAABB_CCDD, 4'h3, 5, 4'b0001, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset during ACCESS of slot 0.
        wait_cfg[0]   = 5;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.paddr_i   = 32'h0000_0020;
        bus.pwrite_i  = 1'b1;
        bus.pwdata_i  = 32'h0000_0055;
        bus.pstrb_i   = 4'hF;
        tick();
        bus.penable_i = 1'b1;
        tick();
        chk("rstacc:penable_pre", bus.penable_o, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstacc:psel", bus.psel_o, 4'b0000);
        chk("rstacc:penable", bus.penable_o, 1'b0);
        chk("rstacc:pready", bus.pready_o, 1'b0);
        chk("rstacc:err_slot", bus.err_slot_o, 3'b000);
        chk("rstacc:paddr", bus.paddr_o, 32'h0);
        chk("rstacc:pwdata", bus.pwdata_o, 32'h0);
        chk("rstacc:pwrite", bus.pwrite_o, 1'b0);
        rst           = 1'b0;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstacc:no_pready", bus.pready_o, 1'b0);
            chk("rstacc:no_psel", bus.psel_o, 4'b0000);
        end
        $display("reset during access done");

        wait_cfg[0] = 0;
        do_xfer("post_rst", 32'h0000_0000, 1'b0, 32'h0, 4'hF, 3, 4'b0001, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
